count_enable_ctrl: RTL and testbench
====================================

COUNT_ENABLE_CTRL -- requirements
Module: count_enable_ctrl

Interface
REQ-001 The block SHALL have parameter BURST_W, default 8, giving the width of the burst length and remaining count.
REQ-002 The block SHALL have port iClk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port iStart, input, 1, start request, sampled only in IDLE.
REQ-005 The block SHALL have port iStop, input, 1, abort request, sampled in every state.
REQ-006 The block SHALL have port iStep, input, 1, single-step request, level input, used in STEP mode.
REQ-007 The block SHALL have port iMode, input, 2, operating mode: 00 free-run, 01 burst, 10 step, 11 reserved.
REQ-008 The block SHALL have port iBurstLen, input, BURST_W, number of enable cycles for burst mode.
REQ-009 The block SHALL have port oE_Count, output, 1, registered count enable driven to the counter bank's E_Count.
REQ-010 The block SHALL have port oBusy, output, 1, high in RUN, BURST and STEP.
REQ-011 The block SHALL have port oDone, output, 1, one-cycle pulse on normal burst completion.
REQ-012 The block SHALL have port oState, output, 3, current FSM state encoding: IDLE=0, RUN=1, BURST=2, STEP=3, DONE=4.
REQ-013 The block SHALL have port oRemain, output, BURST_W, enables still to be issued in the current burst.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN, BURST, STEP and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE, iStart=1 with iStop=0 SHALL capture iMode and iBurstLen at that edge and move to RUN (00), BURST (01) or STEP (10); iMode=11 SHALL leave the FSM in IDLE.
REQ-016 iMode and iBurstLen changes after the capturing edge SHALL have no effect until the next start.
REQ-017 RUN: oE_Count=1 on every cycle, starting the cycle after the start edge, until iStop is sampled.
REQ-018 BURST: oE_Count=1 on exactly N consecutive cycles (N = captured iBurstLen), starting the cycle after the start edge, with oRemain loaded with N and decremented by 1 per enable cycle.
REQ-019 BURST: after the last enable, go to DONE with oE_Count=0, oRemain=0 and oDone=1 for one cycle; DONE SHALL always return to IDLE on the next edge.
REQ-020 BURST with N=0 SHALL issue no enable and enter DONE on the edge after start.
REQ-021 STEP: each 0->1 transition of iStep (registered edge detect) SHALL produce exactly one oE_Count=1 cycle on the following cycle; holding iStep high SHALL produce only one enable.
REQ-022 iStop=1 in RUN, BURST or STEP SHALL force IDLE at the next edge, with oE_Count=0 and oRemain=0 from that edge and no oDone pulse.
REQ-023 iStop SHALL take priority over iStart, the burst terminal count and iStep on the same edge.
REQ-024 iStart while not in IDLE SHALL be ignored and SHALL NOT restart or extend an active operation.
REQ-025 oRemain SHALL never wrap below 0.

Reset
REQ-026 iRst=0 SHALL immediately, independent of iClk, force IDLE, oE_Count=0, oBusy=0, oDone=0, oState=0, oRemain=0 and clear the captured mode, length and step-edge register.
REQ-027 After iRst deasserts, the first iStart SHALL be honoured at the first rising edge at which it is sampled.
REQ-028 Reset asserted mid-operation SHALL abort it with no oDone pulse.

Verification
REQ-029 Burst: iMode=01, iBurstLen=5, iStart pulse -> oE_Count high exactly 5 cycles; oRemain goes 5,4,3,2,1,0; oDone pulses 1 cycle after the last enable; oBusy then 0.
REQ-030 Free-run: iMode=00, start, iStop after 50 cycles -> exactly 50 enable cycles, oDone never 1, IDLE next edge.
REQ-031 Step: iStep held high 4 cycles, then 3 one-cycle pulses -> exactly 4 enable cycles total, each 1 cycle wide.
REQ-032 Edge cases: iBurstLen=0 -> zero enables and oDone 1 cycle after start; iStart and iStop on the same edge in IDLE -> remains IDLE.
REQ-033 Reset mid-burst: iRst=0 at oRemain=3 -> oE_Count=0 and oState=0 asynchronously, no oDone; after release, a new burst of 2 -> 2 enables.

Source files
------------

// File: rtl/count_enable_ctrl.sv
// Count-enable controller: sequences the counter bank's E_Count in free-run,
// fixed-length burst or single-step mode, with abort and completion signalling.
module count_enable_ctrl #(
    parameter int BURST_W = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iStep,
    input  logic [1:0]         iMode,
    input  logic [BURST_W-1:0] iBurstLen,
    output logic               oE_Count,
    output logic               oBusy,
    output logic               oDone,
    output logic [2:0]         oState,
    output logic [BURST_W-1:0] oRemain
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        BURST = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic               stepQ;
    logic               stepRise;
    logic               eCountNext;
    logic               busyNext;
    logic               doneNext;
    logic [BURST_W-1:0] remainNext;

    assign stepRise = iStep & ~stepQ;
    assign oState   = state;

    // The captured mode is the state entered at start, and the captured burst
    // length lives in oRemain, so later input changes cannot reach the operation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        stateNext  = state;
        eCountNext = 1'b0;
        doneNext   = 1'b0;
        remainNext = '0;

        case (state)
            IDLE: begin
                if (iStart && !iStop) begin
                    case (iMode)
                        2'b00: begin
                            stateNext  = RUN;
                            eCountNext = 1'b1;
                        end
                        2'b01: begin
                            stateNext  = BURST;
                            remainNext = iBurstLen;
                            eCountNext = (iBurstLen != '0);
                        end
                        2'b10:   stateNext = STEP;
                        default: stateNext = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (iStop) stateNext = IDLE;
                else       eCountNext = 1'b1;
            end
            BURST: begin
                if (iStop) begin
                    stateNext = IDLE;
                end else if (oRemain <= BURST_W'(1)) begin
                    // Terminal count (or an empty burst): never decrement past zero.
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    remainNext = oRemain - BURST_W'(1);
                    eCountNext = 1'b1;
                end
            end
            STEP: begin
                if (iStop) stateNext = IDLE;
                else       eCountNext = stepRise;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext == RUN) || (stateNext == BURST) || (stateNext == STEP);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            stepQ    <= 1'b0;
            oE_Count <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oRemain  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the pre-edge values.
            state    <= stateNext;
            stepQ    <= iStep;
            oE_Count <= eCountNext;
            oBusy    <= busyNext;
            oDone    <= doneNext;
            oRemain  <= remainNext;
        end
    end

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Bench for count_enable_ctrl: directed operations push expected per-operation
// totals; a negedge monitor accumulates what the DUT did and compares on return to IDLE.
module tb_count_enable_ctrl;

    localparam int BURST_W = 8;

    logic               iClk;
    logic               iRst;
    logic               iStart;
    logic               iStop;
    logic               iStep;
    logic [1:0]         iMode;
    logic [BURST_W-1:0] iBurstLen;
    logic               oE_Count;
    logic               oBusy;
    logic               oDone;
    logic [2:0]         oState;
    logic [BURST_W-1:0] oRemain;

    typedef struct {
        int enables;
        int dones;
        int maxRun;
        int remainSum;
        int busyCycles;
    } txnT;

    txnT   expQ[$];
    string nameQ[$];

    int nCompared   = 0;
    int nMismatched = 0;

    int accEn     = 0;
    int accDone   = 0;
    int accRun    = 0;
    int curRun    = 0;
    int accRemain = 0;
    int accBusy   = 0;

    count_enable_ctrl #(.BURST_W(BURST_W)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iStop     (iStop),
        .iStep     (iStep),
        .iMode     (iMode),
        .iBurstLen (iBurstLen),
        .oE_Count  (oE_Count),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oState    (oState),
        .oRemain   (oRemain)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic expectTxn(input string name, input int en, input int dn, input int run,
                             input int rsum, input int busy);
        txnT t;
        t.enables    = en;
        t.dones      = dn;
        t.maxRun     = run;
        t.remainSum  = rsum;
        t.busyCycles = busy;
        expQ.push_back(t);
        nameQ.push_back(name);
    endtask

    task automatic startOp(input logic [1:0] mode, input logic [BURST_W-1:0] len);
        iStart    = 1'b1;
        iMode     = mode;
        iBurstLen = len;
        tick();
        iStart    = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (oState != 3'd0 && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("wait_idle_timeout", int'(oState), 0);
    endtask

    // Monitor: accumulates observed behaviour and scores it when the FSM re-enters IDLE.
    initial begin : monitor
        logic [2:0] prevState;
        txnT        e;
        string      nm;
        prevState = 3'd0;
        forever begin
            @(negedge iClk);
            if (oE_Count) begin
                accEn++;
                curRun++;
                if (curRun > accRun) accRun = curRun;
            end else begin
                curRun = 0;
            end
            if (oDone) accDone++;
            if (oBusy) accBusy++;
            accRemain += int'(oRemain);
            if (oState == 3'd0 && prevState != 3'd0) begin
                if (expQ.size() == 0) begin
                    check("unexpected_operation", 1, 0);
                end else begin
                    e  = expQ.pop_front();
                    nm = nameQ.pop_front();
                    check({nm, "_enables"}, accEn, e.enables);
                    check({nm, "_dones"}, accDone, e.dones);
                    check({nm, "_max_run"}, accRun, e.maxRun);
                    check({nm, "_remain_sum"}, accRemain, e.remainSum);
                    check({nm, "_busy_cycles"}, accBusy, e.busyCycles);
                end
                accEn     = 0;
                accDone   = 0;
                accRun    = 0;
                curRun    = 0;
                accRemain = 0;
                accBusy   = 0;
            end
            prevState = oState;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        iRst      = 1'b1;
        iStart    = 1'b0;
        iStop     = 1'b0;
        iStep     = 1'b0;
        iMode     = 2'b00;
        iBurstLen = '0;
        #1 iRst = 1'b0;
        #1;
        check("reset_state", int'(oState), 0);
        check("reset_e_count", int'(oE_Count), 0);
        check("reset_busy", int'(oBusy), 0);
        check("reset_done", int'(oDone), 0);
        check("reset_remain", int'(oRemain), 0);
        tick();
        tick();
        iRst = 1'b1;
        tick();

        // Burst of 5: remain 5..1 on enable cycles, 0 in DONE.
        expectTxn("burst5", 5, 1, 5, 15, 5);
        startOp(2'b01, 8'd5);
        waitIdle(20);
        check("burst5_busy_after", int'(oBusy), 0);
        tick();

        // Free-run: stop sampled on the 50th edge after start.
        expectTxn("run50", 50, 0, 50, 0, 50);
        startOp(2'b00, 8'd9);
        repeat (49) tick();
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        check("run50_idle_after_stop", int'(oState), 0);
        tick();

        // Step: held high 4 cycles, then three single-cycle pulses -> 4 enables.
        expectTxn("step", 4, 0, 1, 0, 15);
        startOp(2'b10, 8'd0);
        iStep = 1'b1;
        repeat (4) tick();
        iStep = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            iStep = 1'b1;
            tick();
            iStep = 1'b0;
            tick();
            tick();
        end
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        tick();

        // Empty burst: no enable, DONE on the edge after start.
        expectTxn("burst0", 0, 1, 0, 0, 1);
        startOp(2'b01, 8'd0);
        waitIdle(10);
        tick();

        // Start and stop together in IDLE: stays IDLE.
        iStart = 1'b1;
        iStop  = 1'b1;
        iMode  = 2'b00;
        tick();
        iStart = 1'b0;
        iStop  = 1'b0;
        check("start_stop_idle_state", int'(oState), 0);
        check("start_stop_idle_busy", int'(oBusy), 0);

        // Reserved mode: stays IDLE.
        startOp(2'b11, 8'd4);
        check("reserved_mode_state", int'(oState), 0);
        check("reserved_mode_e_count", int'(oE_Count), 0);
        tick();

        // Restart attempt mid-burst with changed mode/length is ignored.
        expectTxn("burst3_restart", 3, 1, 3, 6, 3);
        startOp(2'b01, 8'd3);
        tick();
        iStart    = 1'b1;
        iMode     = 2'b00;
        iBurstLen = 8'd200;
        tick();
        iStart    = 1'b0;
        waitIdle(20);
        tick();

        // Stop mid-burst: abort with no DONE pulse.
        expectTxn("burst6_stop", 2, 0, 2, 11, 2);
        startOp(2'b01, 8'd6);
        tick();
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        check("burst6_stop_remain", int'(oRemain), 0);
        check("burst6_stop_e_count", int'(oE_Count), 0);
        check("burst6_stop_state", int'(oState), 0);
        tick();

        // Reset at remain=3 aborts asynchronously.
        expectTxn("burst5_reset", 2, 0, 2, 9, 2);
        startOp(2'b01, 8'd5);
        tick();
        tick();
        check("pre_reset_remain", int'(oRemain), 3);
        iRst = 1'b0;
        #1;
        check("async_reset_e_count", int'(oE_Count), 0);
        check("async_reset_state", int'(oState), 0);
        check("async_reset_remain", int'(oRemain), 0);
        check("async_reset_done", int'(oDone), 0);
        tick();
        tick();
        iRst = 1'b1;

        // First start after reset release is honoured immediately.
        expectTxn("burst2_after_reset", 2, 1, 2, 3, 2);
        startOp(2'b01, 8'd2);
        check("burst2_first_state", int'(oState), 2);
        waitIdle(20);
        repeat (3) tick();

        check("pending_expectations", expQ.size(), 0);
        check("stray_enables", accEn, 0);
        check("stray_dones", accDone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
